tile_reset_sequencer: RTL
=========================

# tile_reset_sequencer

Parametrised reset sequencer for the multi-tile wrapper. On global reset it holds every BoomTile in reset for a programmable time, then releases the tiles one at a time at a fixed stagger. After boot it services per-tile soft-reset requests: it asks the tile to quiesce, drains the tile's outstanding TileLink traffic (bounded by a timeout), then pulses that tile's reset. It sits between the top-level reset and each tile's `reset` pin.

## Interface
Parameters:
- NUM_TILES, 4: number of tiles sequenced (≥1).
- HOLD_CYCLES, 2: cycles tile reset is held, at boot and per soft reset (≥1).
- STAGGER_CYCLES, 1: cycles between successive tile releases at boot (≥1).
- DRAIN_TIMEOUT, 256: maximum cycles spent in drain before forcing reset (≥1).
- Counter width is derived internally: clog2(max(HOLD_CYCLES, STAGGER_CYCLES, DRAIN_TIMEOUT)+1).

Ports:
- clock  in  1  sole clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high global reset.
- sw_reset_req  in  NUM_TILES  one-cycle request pulse per tile.
- tl_busy  in  NUM_TILES  tile i has outstanding TileLink A/C/E or pending D.
- tile_reset  out  NUM_TILES  per-tile reset, active-high, registered.
- tile_quiesce  out  NUM_TILES  asks tile i to stop issuing new TileLink requests.
- boot_done  out  1  all tiles released after global reset; sticky until reset.
- srst_active  out  1  a soft-reset sequence is in drain or assert.
- srst_idx  out  clog2(NUM_TILES) (min 1)  tile being soft-reset; 0 when idle.
- drain_timeout  out  1  sticky; set when any drain hit DRAIN_TIMEOUT.

## Operation
- All outputs are registered. Reset values: tile_reset all 1, tile_quiesce 0, boot_done 0, srst_active 0, srst_idx 0, drain_timeout 0. Reset also clears the pending vector, the counter and the state, and sets state to HOLD.
- pending[NUM_TILES-1:0] is sticky: bit i is set by sw_reset_req[i] in any state, including boot. A request for the tile currently in DRAIN or SRST re-sets its bit, which causes a second sequence later. Set and clear in the same cycle resolve as set.
- FSM states:
  - HOLD: count HOLD_CYCLES cycles, then clear tile_reset[0] and go to STAGGER, or to RUN if NUM_TILES=1.
  - STAGGER: every STAGGER_CYCLES cycles clear the next tile_reset bit in ascending index order. Set boot_done in the same edge that clears the last bit, then go to RUN.
  - RUN: if pending is non-zero, select the lowest index j, clear pending[j], set srst_idx=j, srst_active=1 and tile_quiesce[j]=1, then go to DRAIN with the counter cleared.
  - DRAIN:
    - If tl_busy[j]=0, set tile_reset[j]=1 and go to SRST.
    - Otherwise increment the counter. At count DRAIN_TIMEOUT-1, set tile_reset[j]=1 and drain_timeout=1, then go to SRST.
  - SRST: hold tile_reset[j] for HOLD_CYCLES cycles. Then clear tile_reset[j], tile_quiesce[j] and srst_active, and return to RUN.
- At most one soft-reset sequence runs at a time. Other tiles are unaffected throughout.
- Global reset asserted mid-sequence returns every output to its reset value on the next edge. Pending requests are lost.

## Timing
- Cycle 0 is the first cycle with reset low. tile_reset[i] is first low in cycle HOLD_CYCLES + i·STAGGER_CYCLES. boot_done is first high in the same cycle as the last release.
- Soft reset when tl_busy[j] is already low, with the request pulse in cycle t during RUN and pending empty:
  - pending[j] is visible at t+1.
  - tile_quiesce[j] and srst_active are high from t+2.
  - tile_reset[j] is high in cycles t+3 … t+2+HOLD_CYCLES.
  - tile_quiesce[j] and srst_active are low from t+3+HOLD_CYCLES.
- At least one RUN cycle separates back-to-back sequences.
- Drain timeout: with DRAIN entered in cycle d and tl_busy[j] held high, tile_reset[j] and drain_timeout are first high in cycle d+DRAIN_TIMEOUT.
- Requests during boot are serviced starting the first cycle after entering RUN.

## Test plan
- Boot, defaults (N=4, HOLD=2, STAGGER=1), tl_busy=0 → tile_reset releases tile0 at cycle 2, tile1 at 3, tile2 at 4, tile3 at 5; boot_done=1 at cycle 5; all other outputs 0.
- After boot, sw_reset_req[2] pulse at t, tl_busy=0 → tile_quiesce[2] high t+2..t+4; tile_reset[2] high exactly t+3..t+4; srst_idx=2; other tiles stay 0.
- Simultaneous pulses on req[3] and req[1] in RUN → tile1 sequence first, one RUN gap, then tile3; pending empty afterward.
- DRAIN_TIMEOUT=8, sw_reset_req[0], tl_busy[0] held 1 → tile_reset[0] rises 8 cycles after DRAIN entry; drain_timeout=1 and stays 1 after sequence ends.
- tl_busy[1] drops 3 cycles into drain → tile_reset[1] rises the next cycle; drain_timeout stays 0.
- Global reset pulsed during SRST of tile2 and while req[0] is pending → next cycle all tile_reset=1, boot_done=0, pending cleared; full boot sequence repeats; tile0 is not soft-reset afterward.

Source files
------------

// File: rtl/tile_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tile_reset_sequencer
//
// Drives the per-tile reset pins of the multi-tile wrapper.
//
// After global reset, every tile is held in reset for HOLD_CYCLES cycles.
// The tiles are then released one at a time, in ascending index order, one
// release every STAGGER_CYCLES cycles.
//
// After boot, the block services per-tile soft-reset requests one at a time:
//   1. The tile is asked to quiesce.
//   2. Its outstanding TileLink traffic is allowed to drain. The drain is
//      bounded by DRAIN_TIMEOUT cycles.
//   3. The tile's reset is pulsed for HOLD_CYCLES cycles.
//
// Ports
//   clock          sole clock
//   reset          synchronous, active-high global reset
//   sw_reset_req   per-tile one-cycle soft-reset request pulse
//   tl_busy        per-tile "TileLink traffic still outstanding"
//   tile_reset     per-tile reset, active-high, registered
//   tile_quiesce   per-tile request to stop issuing new TileLink traffic
//   boot_done      all tiles released after global reset (sticky)
//   srst_active    a soft-reset sequence is in drain or assert
//   srst_idx       tile currently being soft-reset, 0 when idle
//   drain_timeout  sticky flag: some drain was cut short by the timeout
// ----------------------------------------------------------------------------
module tile_reset_sequencer #(
  parameter int NUM_TILES      = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int STAGGER_CYCLES = 1,
  parameter int DRAIN_TIMEOUT  = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_TILES-1:0] sw_reset_req,
  input  logic [NUM_TILES-1:0] tl_busy,
  output logic [NUM_TILES-1:0] tile_reset,
  output logic [NUM_TILES-1:0] tile_quiesce,
  output logic                 boot_done,
  output logic                 srst_active,
  output logic [((NUM_TILES > 1) ? $clog2(NUM_TILES) : 1)-1:0] srst_idx,
  output logic                 drain_timeout
);

  localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  // One shared counter serves the hold, stagger and drain phases, so it is
  // sized for the largest of the three.
  localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_CNT = (MAX_HS > DRAIN_TIMEOUT) ? MAX_HS : DRAIN_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_TILE    = IDX_W'(NUM_TILES - 1);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_STAGGER,
    ST_RUN,
    ST_DRAIN,
    ST_SRST
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     boot_idx, boot_idx_nxt;
  logic [NUM_TILES-1:0] pending, pending_nxt;
  logic [NUM_TILES-1:0] pend_clr;

  logic [NUM_TILES-1:0] tile_reset_nxt;
  logic [NUM_TILES-1:0] tile_quiesce_nxt;
  logic                 boot_done_nxt;
  logic                 srst_active_nxt;
  logic [IDX_W-1:0]     srst_idx_nxt;
  logic                 drain_timeout_nxt;

  logic [IDX_W-1:0]     sel_idx;
  logic [NUM_TILES-1:0] sel_oh;
  logic [NUM_TILES-1:0] cur_oh;

  // Fixed priority: the lowest-numbered pending tile is serviced first.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_TILES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign sel_idx = lowest_set(pending);
  assign sel_oh  = NUM_TILES'(1) << sel_idx;
  assign cur_oh  = NUM_TILES'(1) << srst_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_HOLD;
      cnt           <= '0;
      boot_idx      <= '0;
      pending       <= '0;
      tile_reset    <= '1;
      tile_quiesce  <= '0;
      boot_done     <= 1'b0;
      srst_active   <= 1'b0;
      srst_idx      <= '0;
      drain_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      boot_idx      <= boot_idx_nxt;
      pending       <= pending_nxt;
      tile_reset    <= tile_reset_nxt;
      tile_quiesce  <= tile_quiesce_nxt;
      boot_done     <= boot_done_nxt;
      srst_active   <= srst_active_nxt;
      srst_idx      <= srst_idx_nxt;
      drain_timeout <= drain_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    boot_idx_nxt      = boot_idx;
    tile_reset_nxt    = tile_reset;
    tile_quiesce_nxt  = tile_quiesce;
    boot_done_nxt     = boot_done;
    srst_active_nxt   = srst_active;
    srst_idx_nxt      = srst_idx;
    drain_timeout_nxt = drain_timeout;
    pend_clr          = '0;

    case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt           = '0;
          tile_reset_nxt[0] = 1'b0;
          if (NUM_TILES == 1) begin
            boot_done_nxt = 1'b1;
            state_nxt     = ST_RUN;
          end else begin
            boot_idx_nxt = IDX_ONE;
            state_nxt    = ST_STAGGER;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      ST_STAGGER: begin
        if (cnt == STAGGER_LAST) begin
          cnt_nxt                  = '0;
          tile_reset_nxt[boot_idx] = 1'b0;
          if (boot_idx == LAST_TILE) begin
            boot_done_nxt = 1'b1;
            state_nxt     = ST_RUN;
          end else begin
            boot_idx_nxt = boot_idx + IDX_ONE;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (|pending) begin
          pend_clr         = sel_oh;
          srst_idx_nxt     = sel_idx;
          srst_active_nxt  = 1'b1;
          tile_quiesce_nxt = tile_quiesce | sel_oh;
          cnt_nxt          = '0;
          state_nxt        = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // An idle tile goes straight to reset. A busy tile is reset anyway
        // once the drain budget is spent, and the event is flagged.
        if (!tl_busy[srst_idx]) begin
          tile_reset_nxt = tile_reset | cur_oh;
          cnt_nxt        = '0;
          state_nxt      = ST_SRST;
        end else if (cnt == DRAIN_LAST) begin
          tile_reset_nxt    = tile_reset | cur_oh;
          drain_timeout_nxt = 1'b1;
          cnt_nxt           = '0;
          state_nxt         = ST_SRST;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      ST_SRST: begin
        if (cnt == HOLD_LAST) begin
          tile_reset_nxt   = tile_reset & ~cur_oh;
          tile_quiesce_nxt = tile_quiesce & ~cur_oh;
          srst_active_nxt  = 1'b0;
          srst_idx_nxt     = '0;
          cnt_nxt          = '0;
          state_nxt        = ST_RUN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = ST_HOLD;
      end
    endcase

    // A new request wins over the clear of the tile being started, so a
    // request arriving in that same cycle schedules a second sequence.
    pending_nxt = (pending & ~pend_clr) | sw_reset_req;
  end

endmodule
